// File: rtl/demux_deserializer.sv
// Serial-to-parallel demultiplexer: accepted bits fill lanes LSB-first, the full word is held until the consumer takes it.
// Optional even-parity trailer bit and parity_error output when DEMUX_DESERIALIZER_PARITY_EN is defined.
module demux_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     data_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_index
`ifdef DEMUX_DESERIALIZER_PARITY_EN
    ,
    output logic                     parity_error
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [WIDTH-1:0]   data_reg, data_next;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
    logic               par_wait_reg, par_wait_next;
    logic               perr_reg, perr_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= COLLECT;
            idx_reg      <= '0;
            data_reg     <= '0;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
            par_wait_reg <= 1'b0;
            perr_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            data_reg     <= data_next;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
            par_wait_reg <= par_wait_next;
            perr_reg     <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        data_next     = data_reg;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        par_wait_next = par_wait_reg;
        perr_next     = perr_reg;
`endif
        if (flush) begin
            state_next    = COLLECT;
            idx_next      = '0;
            data_next     = '0;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
            par_wait_next = 1'b0;
            perr_next     = 1'b0;
`endif
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (in_valid) begin
`ifdef DEMUX_DESERIALIZER_PARITY_EN
                        // Trailer bit: occupies no lane, only folds into the parity check.
                        if (par_wait_reg) begin
                            perr_next     = (^data_reg) ^ data_in;
                            par_wait_next = 1'b0;
                            idx_next      = '0;
                            state_next    = HOLD;
                        end else
`endif
                        begin
                            data_next[idx_reg] = data_in;
                            if (idx_reg == LAST) begin
`ifdef DEMUX_DESERIALIZER_PARITY_EN
                                par_wait_next = 1'b1;
`else
                                idx_next   = '0;
                                state_next = HOLD;
`endif
                            end else begin
                                idx_next = idx_reg + ONE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = COLLECT;
                        data_next  = '0;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
                        perr_next  = 1'b0;
`endif
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    assign in_ready     = (state_reg == COLLECT);
    assign out_valid    = (state_reg == HOLD);
    assign data_out     = data_reg;
    assign bit_index    = idx_reg;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
    assign parity_error = perr_reg;
`endif

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed self-checking bench for demux_deserializer (WIDTH=8); parity checks are built when DEMUX_DESERIALIZER_PARITY_EN is defined.
module tb_demux_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       data_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] bit_index;
`ifdef DEMUX_DESERIALIZER_PARITY_EN
    logic       parity_error;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_deserializer #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bit_index    (bit_index)
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    // Stimulus drivers: inputs change on the falling edge, outputs are sampled there too.
    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in  = b;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        send_bit(^w);
`endif
        idle();
    endtask

    task automatic complete();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        idle();
        checks++;
        if (bit_index !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset_index got=%0d want=2", bit_index);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1 || bit_index !== 3'd0) begin
            failures++;
            $display("FAIL async_reset got data=%h ov=%b ir=%b idx=%0d want data=00 ov=0 ir=1 idx=0",
                     data_out, out_valid, in_ready, bit_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'h4D;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        checks++;
        if (out_valid !== 1'b0 || bit_index !== 3'd7) begin
            failures++;
            $display("FAIL basic_before_last got ov=%b idx=%0d want ov=0 idx=7", out_valid, bit_index);
        end
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        send_bit(^w);
`endif
        idle();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'h4D) begin
            failures++;
            $display("FAIL basic_word got ov=%b ir=%b data=%h want ov=1 ir=0 data=4d", out_valid, in_ready, data_out);
        end
        complete();
        checks++;
        if (out_valid !== 1'b0 || data_out !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_complete got ov=%b data=%h ir=%b want ov=0 data=00 ir=1", out_valid, data_out, in_ready);
        end
        $display("test_basic done data=4d");
    endtask

    task automatic test_backpressure();
        send_frame(8'h4D);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            data_in  = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 8'h4D || bit_index !== 3'd0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b data=%h idx=%0d want ov=1 ir=0 data=4d idx=0",
                         c, out_valid, in_ready, data_out, bit_index);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 8'h00 || bit_index !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got ov=%b data=%h idx=%0d ir=%b want ov=0 data=00 idx=0 ir=1",
                     out_valid, data_out, bit_index, in_ready);
        end
        send_frame(8'h3C);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h3C) begin
            failures++;
            $display("FAIL bp_next_word got ov=%b data=%h want ov=1 data=3c", out_valid, data_out);
        end
        complete();
        $display("test_backpressure done");
    endtask

    task automatic test_idle();
        logic [7:0] w;
        w = 8'h65;
        for (int i = 0; i < 3; i++) send_bit(w[i]);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (bit_index !== 3'd3 || data_out !== 8'h05 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got idx=%0d data=%h ir=%b ov=%b want idx=3 data=05 ir=1 ov=0",
                     bit_index, data_out, in_ready, out_valid);
        end
        for (int i = 3; i < 8; i++) send_bit(w[i]);
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        send_bit(^w);
`endif
        idle();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h65) begin
            failures++;
            $display("FAIL idle_word got ov=%b data=%h want ov=1 data=65", out_valid, data_out);
        end
        complete();
        $display("test_idle done");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk);
        flush    = 1'b1;
        data_in  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bit_index !== 3'd0 || data_out !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_partial got idx=%0d data=%h ir=%b want idx=0 data=00 ir=1", bit_index, data_out, in_ready);
        end
        send_frame(8'hFF);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hFF) begin
            failures++;
            $display("FAIL flush_word got ov=%b data=%h want ov=1 data=ff", out_valid, data_out);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 8'h00 || in_ready !== 1'b1 || bit_index !== 3'd0) begin
            failures++;
            $display("FAIL flush_hold got ov=%b data=%h ir=%b idx=%0d want ov=0 data=00 ir=1 idx=0",
                     out_valid, data_out, in_ready, bit_index);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if (bit_index !== 3'd0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL midword_reset got idx=%0d data=%h want idx=0 data=00", bit_index, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hA5);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL midword_word got ov=%b data=%h want ov=1 data=a5", out_valid, data_out);
        end
        complete();
        $display("test_reset_midword done");
    endtask

`ifdef DEMUX_DESERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [7:0] w;
        logic       pbit;
        w = 8'h4D;
        for (int k = 0; k < 2; k++) begin
            pbit = (k == 1);
            for (int i = 0; i < 8; i++) send_bit(w[i]);
            @(negedge clk);
            checks++;
            if (bit_index !== 3'd7 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL parity_wait got idx=%0d ov=%b ir=%b want idx=7 ov=0 ir=1", bit_index, out_valid, in_ready);
            end
            data_in  = pbit;
            in_valid = 1'b1;
            idle();
            checks++;
            if (out_valid !== 1'b1 || data_out !== 8'h4D || parity_error !== pbit) begin
                failures++;
                $display("FAIL parity_result pbit=%b got ov=%b data=%h perr=%b want ov=1 data=4d perr=%b",
                         pbit, out_valid, data_out, parity_error, pbit);
            end
            complete();
            checks++;
            if (parity_error !== 1'b0) begin
                failures++;
                $display("FAIL parity_clear got perr=%b want 0", parity_error);
            end
        end
        $display("test_parity done");
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        data_in   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_idle();
        test_flush();
        test_reset_midword();
`ifdef DEMUX_DESERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
